chunked_serial_adder: RTL and testbench

- Parametrised multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through one registered CHUNK-bit ripple slice.
- Trades latency for area in gate-level fault-simulation and test-generation netlists.
- Start/ready/done handshake; result held until the next operation is accepted.

---
 rtl/chunked_serial_adder_pkg.sv | 15 +
 rtl/chunked_serial_adder_if.sv | 31 +++
 rtl/chunked_serial_adder_ripple.sv | 20 ++
 rtl/chunked_serial_adder.sv | 120 ++++++++++++
 tb/tb_chunked_serial_adder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/chunked_serial_adder_pkg.sv
// Shared types for the chunked serial adder: FSM state encoding and a
// constant clog2 used to size the chunk index.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Never returns less than 1, so a single-chunk build still gets a real index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Request/result bundle for chunked_serial_adder. The sub signal exists only
// when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             ci;
`ifdef CHUNKED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             done;

  modport master (
    output start, i0, i1, ci,
`ifdef CHUNKED_ADDER_SUB_EN
    output sub,
`endif
    input  ready, s, co, done
  );

  modport slave (
    input  start, i0, i1, ci,
`ifdef CHUNKED_ADDER_SUB_EN
    input  sub,
`endif
    output ready, s, co, done
  );
endinterface

// File: rtl/chunked_serial_adder_ripple.sv
// Combinational W-bit ripple of full-adder cells; the one arithmetic slice
// the serial adder reuses every cycle.
module chunk_ripple_adder #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, LSB first.
// Define CHUNKED_ADDER_SUB_EN to add a subtract control (sub) on the interface.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  chunked_serial_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_serial_adder: CHUNK must be >=1 and divide WIDTH");
  end

  state_e                         state_q, state_d;
  logic [NCHUNK-1:0][CHUNK-1:0]   a_q, a_d, b_q, b_d, shadow_q, shadow_d;
  logic                           carry_q, carry_d;
  logic [IDXW-1:0]                idx_q, idx_d;
  logic [WIDTH-1:0]               s_q, s_d;
  logic                           co_q, co_d;

  logic [CHUNK-1:0]               a_cur, b_cur, sum;
  logic                           c_out, accept, last;
  logic [WIDTH-1:0]               b_in;
  logic                           c_in;

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int k = 0; k < NCHUNK; k++)
      if (idx_q == IDXW'(k)) begin
        a_cur = a_q[k];
        b_cur = b_q[k];
      end
  end

  chunk_ripple_adder #(.W(CHUNK)) u_rip (
    .a(a_cur), .b(b_cur), .cin(carry_q), .s(sum), .cout(c_out)
  );

  // Subtraction is A + ~B + ~ci, folded in once at the accept edge.
`ifdef CHUNKED_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.i1 : bus.i1;
  assign c_in = bus.ci ^ bus.sub;
`else
  assign b_in = bus.i1;
  assign c_in = bus.ci;
`endif

  assign accept = bus.start && (state_q != BUSY);
  assign last   = (idx_q == IDXW'(NCHUNK - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    co_d     = co_q;
    case (state_q)
      BUSY: begin
        for (int k = 0; k < NCHUNK; k++)
          if (idx_q == IDXW'(k)) shadow_d[k] = sum;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          s_d     = shadow_d;
          co_d    = c_out;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: begin
        if (accept) begin
          a_d     = bus.i0;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      co_q     <= co_d;
    end
  end

  assign bus.ready = (state_q != BUSY);
  assign bus.done  = (state_q == DONE);
  assign bus.s     = s_q;
  assign bus.co    = co_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: cycle model of the 8/2 build checked every
// cycle, plus literal checks of each result and a 4/4 single-chunk instance.
module tb_chunked_serial_adder;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(W)) bus ();
  chunked_serial_adder_if #(.WIDTH(4)) bus4 ();

  chunked_serial_adder #(.WIDTH(W), .CHUNK(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request resolves to (i0 +/- i1 +/- ci) NCH+1 cycles later.
  int         m_rem = 0;
  logic [W:0] m_pend;
  logic       m_done, m_co;
  logic [W-1:0] m_s;
  logic       m_sub;

`ifdef CHUNKED_ADDER_SUB_EN
  assign m_sub = bus.sub;
`else
  assign m_sub = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0; m_done <= 1'b0; m_s <= '0; m_co <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0 && bus.start) begin
        if (m_sub) m_pend <= {1'b0, bus.i0} + {1'b0, ~bus.i1} + (W+1)'(~bus.ci);
        else       m_pend <= {1'b0, bus.i0} + {1'b0, bus.i1} + (W+1)'(bus.ci);
        m_rem <= NCH;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_co, m_s} <= m_pend;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", bus.ready, m_rem == 0);
      chk("model_done",  bus.done,  m_done);
      chk("model_s",     bus.s,     m_s);
      chk("model_co",    bus.co,    m_co);
    end
  end

  // Called on a negedge with ready=1; returns on the first negedge after accept.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
    bus.start = 1'b1; bus.i0 = a; bus.i1 = b; bus.ci = c;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub = sb;
`endif
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // n counts cycles after the accept edge until done; busy counts ready=0 cycles.
  task automatic wait_done(input logic [7:0] hold_s, input bit chk_hold, input bit inject,
                           output int n, output int busy);
    n = 1; busy = 0;
    while (!bus.done && n < 20) begin
      if (!bus.ready) busy++;
      if (chk_hold) chk("hold_prev_s", bus.s, hold_s);
      if (inject && n == 2) begin
        bus.start = 1'b1; bus.i0 = 8'hC3; bus.i1 = 8'h3C; bus.ci = 1'b1;
      end else if (inject && n == 3) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                    input logic sb, input logic [7:0] es, input logic eco, input bit inject);
    int n, busy;
    launch(a, b, c, sb);
    wait_done(8'h00, 1'b0, inject, n, busy);
    chk({nm, "_latency"}, n, 5);
    chk({nm, "_busy"}, busy, 4);
    chk({nm, "_s"}, bus.s, es);
    chk({nm, "_co"}, bus.co, eco);
    @(negedge clk);
  endtask

  task automatic op4(input string nm, input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic sb, input logic [3:0] es, input logic eco);
    bus4.start = 1'b1; bus4.i0 = a; bus4.i1 = b; bus4.ci = c;
`ifdef CHUNKED_ADDER_SUB_EN
    bus4.sub = sb;
`endif
    @(negedge clk);
    bus4.start = 1'b0;
    chk({nm, "_busy_ready"}, bus4.ready, 1'b0);
    chk({nm, "_busy_done"}, bus4.done, 1'b0);
    @(negedge clk);
    chk({nm, "_done"}, bus4.done, 1'b1);
    chk({nm, "_s"}, bus4.s, es);
    chk({nm, "_co"}, bus4.co, eco);
    @(negedge clk);
    chk({nm, "_idle_done"}, bus4.done, 1'b0);
    chk({nm, "_idle_ready"}, bus4.ready, 1'b1);
  endtask

  initial begin
    int n, busy;
    rst = 1'b1;
    bus.start = 1'b0; bus.i0 = '0; bus.i1 = '0; bus.ci = 1'b0;
    bus4.start = 1'b0; bus4.i0 = '0; bus4.i1 = '0; bus4.ci = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub = 1'b0; bus4.sub = 1'b0;
`endif
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done",  bus.done,  1'b0);
    chk("rst_s",     bus.s,     8'h00);
    chk("rst_co",    bus.co,    1'b0);
    chk("rst4_ready", bus4.ready, 1'b1);
    chk("rst4_s",     bus4.s,     4'h0);
    repeat (3) @(negedge clk);
    chk("idle_done", bus.done, 1'b0);

    op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("5a_33", 8'h5A, 8'h33, 1'b1, 1'b0, 8'h8E, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ignored_start_s",  bus.s,  8'h8E);
    chk("ignored_start_co", bus.co, 1'b0);

    // Back-to-back: start held in the DONE cycle of the first operation.
    launch(8'h01, 8'h02, 1'b0, 1'b0);
    wait_done(8'h00, 1'b0, 1'b0, n, busy);
    chk("b2b_first_s", bus.s, 8'h03);
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(8'h03, 1'b1, 1'b0, n, busy);
    chk("b2b_latency", n, 5);
    chk("b2b_s", bus.s, 8'h30);
    chk("b2b_co", bus.co, 1'b0);
    @(negedge clk);

    // Reset in the 2nd BUSY cycle aborts the operation.
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_s", bus.s, 8'h00);
    chk("abort_co", bus.co, 1'b0);
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_done", bus.done, 1'b0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("abort_no_done", n, 0);

    op4("w4_add", 4'h9, 4'h9, 1'b1, 1'b0, 4'h3, 1'b1);
`ifdef CHUNKED_ADDER_SUB_EN
    op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op("sub_7_5", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    op("sub0_add", 8'h5A, 8'h33, 1'b1, 1'b0, 8'h8E, 1'b0, 1'b0);
    op4("w4_sub", 4'h9, 4'h9, 1'b1, 1'b1, 4'hF, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
